// File: rtl/bank_scheduler_if.sv
// Request/grant bundle between the channel controllers (master) and bank_scheduler (slave).
interface bank_scheduler_if #(
    parameter int CHANNELS  = 4,
    parameter int BANK_BITS = 2
);
    // Handshake: req[i] is a level held with a stable req_bank slice until the
    // scheduler answers with a one-cycle grant[i] pulse; the requester must drop
    // req[i] or move req_bank the cycle after it sees that grant. grant_valid is
    // the OR of grant and grant_bank names the bank being granted.
    logic [CHANNELS-1:0]           req;
    logic [CHANNELS*BANK_BITS-1:0] req_bank;
    logic [CHANNELS-1:0]           grant;
    logic                          grant_valid;
    logic [BANK_BITS-1:0]          grant_bank;

    modport master (
        output req, req_bank,
        input  grant, grant_valid, grant_bank
    );

    modport slave (
        input  req, req_bank,
        output grant, grant_valid, grant_bank
    );
endinterface

// File: rtl/bank_scheduler.sv
// Bank scheduler: one grant per cycle to a free bank, per-bank recovery timers, refresh debt tracking.
// Optional SCHED_STATS_EN adds saturating grant/refresh/forced-refresh counters.
module bank_scheduler #(
    parameter int CHANNELS     = 4,
    parameter int BANKS        = 4,
    parameter int BANK_BITS    = 2,
    parameter int MAX_POSTPONE = 8,
    parameter int T_BUSY       = 4,
    parameter int T_RFC        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           arb_mode,
    input  logic [31:0]          refresh_interval,
    bank_scheduler_if.slave      bus,
    output logic [BANKS-1:0]     bank_busy,
    output logic                 ref_active,
    output logic [3:0]           ref_pending,
    output logic                 idle,
    output logic [1:0]           state_dbg
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]          stat_grants,
    output logic [15:0]          stat_refreshes,
    output logic [15:0]          stat_forced
`endif
);

    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BUSY_W = $clog2(T_BUSY + 1);
    localparam int RFC_W  = $clog2(T_RFC + 1);
    localparam logic [3:0] MAX_P = 4'(MAX_POSTPONE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_REFRESH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [RFC_W-1:0]     rfc_cnt_q, rfc_cnt_d;
    logic [31:0]          timer_q, timer_d;
    logic [3:0]           pending_q, pending_d;
    logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CHANNELS-1:0]  grant_q, grant_d;
    logic [BANK_BITS-1:0] grant_bank_q, grant_bank_d;
    logic [BUSY_W-1:0]    busy_cnt_q [BANKS];
    logic [BUSY_W-1:0]    busy_cnt_d [BANKS];

    logic                 arb_ok;
    logic                 ref_done;
    logic                 forced_entry;
    logic                 tick;
    logic [CHANNELS-1:0]  elig;
    logic                 pick_valid;
    logic [CH_W-1:0]      pick_idx;
    logic [CH_W:0]        rr_sum;
    logic [CH_W-1:0]      rr_idx;

    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            bank_busy[b] = (busy_cnt_q[b] != '0);
        end
    end

    // FSM: IDLE arbitrates; any refresh decision in IDLE suppresses that cycle's grant.
    always_comb begin
        state_d      = state_q;
        rfc_cnt_d    = rfc_cnt_q;
        arb_ok       = 1'b0;
        ref_done     = 1'b0;
        forced_entry = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q == MAX_P) begin
                    state_d      = ST_DRAIN;
                    forced_entry = 1'b1;
                end else if ((pending_q != 4'd0) && (bus.req == '0)) begin
                    state_d = ST_DRAIN;
                end else begin
                    arb_ok = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bank_busy == '0) begin
                    state_d   = ST_REFRESH;
                    rfc_cnt_d = '0;
                end
            end
            ST_REFRESH: begin
                if (rfc_cnt_q == RFC_W'(T_RFC - 1)) begin
                    state_d  = ST_IDLE;
                    ref_done = 1'b1;
                end else begin
                    rfc_cnt_d = rfc_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A >= compare (not ==) lets a shrunken interval take effect on the very next cycle.
    always_comb begin
        timer_d = timer_q;
        tick    = 1'b0;
        if (refresh_interval != 32'd0) begin
            if (timer_q >= refresh_interval - 32'd1) begin
                timer_d = 32'd0;
                tick    = 1'b1;
            end else begin
                timer_d = timer_q + 32'd1;
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (tick && !ref_done) begin
            if (pending_q != MAX_P) begin
                pending_d = pending_q + 4'd1;
            end
        end else if (!tick && ref_done) begin
            pending_d = pending_q - 4'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            elig[i] = bus.req[i] && enable && arb_ok &&
                      !bank_busy[bus.req_bank[i*BANK_BITS +: BANK_BITS]];
        end
    end

    // Both scans run from the far end backwards so the last hit is the winner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        rr_sum     = '0;
        rr_idx     = '0;
        if (arb_mode == 2'd1) begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    pick_valid = 1'b1;
                    pick_idx   = CH_W'(i);
                end
            end
        end else begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                rr_sum = {1'b0, rr_ptr_q} + (CH_W + 1)'(k);
                if (rr_sum >= (CH_W + 1)'(CHANNELS)) begin
                    rr_sum = rr_sum - (CH_W + 1)'(CHANNELS);
                end
                rr_idx = rr_sum[CH_W-1:0];
                if (elig[rr_idx]) begin
                    pick_valid = 1'b1;
                    pick_idx   = rr_idx;
                end
            end
        end
    end

    always_comb begin
        grant_d      = '0;
        grant_bank_d = '0;
        rr_ptr_d     = rr_ptr_q;
        for (int b = 0; b < BANKS; b++) begin
            busy_cnt_d[b] = (busy_cnt_q[b] != '0) ? busy_cnt_q[b] - 1'b1 : '0;
        end
        if (pick_valid) begin
            grant_d[pick_idx] = 1'b1;
            grant_bank_d      = bus.req_bank[pick_idx*BANK_BITS +: BANK_BITS];
            rr_ptr_d          = (pick_idx == CH_W'(CHANNELS - 1)) ? '0 : pick_idx + 1'b1;
            busy_cnt_d[grant_bank_d] = BUSY_W'(T_BUSY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rfc_cnt_q    <= '0;
            timer_q      <= 32'd0;
            pending_q    <= 4'd0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            grant_bank_q <= '0;
            for (int b = 0; b < BANKS; b++) begin
                busy_cnt_q[b] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rfc_cnt_q    <= rfc_cnt_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            grant_bank_q <= grant_bank_d;
            for (int b = 0; b < BANKS; b++) begin
                busy_cnt_q[b] <= busy_cnt_d[b];
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.grant_bank  = grant_bank_q;
    assign ref_active      = (state_q == ST_REFRESH);
    assign ref_pending     = pending_q;
    assign idle            = (state_q == ST_IDLE) && (bank_busy == '0);
    assign state_dbg       = state_q;

`ifdef SCHED_STATS_EN
    logic [15:0] stat_grants_q, stat_grants_d;
    logic [15:0] stat_refreshes_q, stat_refreshes_d;
    logic [15:0] stat_forced_q, stat_forced_d;

    always_comb begin
        stat_grants_d    = stat_grants_q;
        stat_refreshes_d = stat_refreshes_q;
        stat_forced_d    = stat_forced_q;
        if (pick_valid && (stat_grants_q != 16'hffff)) begin
            stat_grants_d = stat_grants_q + 16'd1;
        end
        if (ref_done && (stat_refreshes_q != 16'hffff)) begin
            stat_refreshes_d = stat_refreshes_q + 16'd1;
        end
        if (forced_entry && (stat_forced_q != 16'hffff)) begin
            stat_forced_d = stat_forced_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grants_q    <= 16'd0;
            stat_refreshes_q <= 16'd0;
            stat_forced_q    <= 16'd0;
        end else begin
            stat_grants_q    <= stat_grants_d;
            stat_refreshes_q <= stat_refreshes_d;
            stat_forced_q    <= stat_forced_d;
        end
    end

    assign stat_grants    = stat_grants_q;
    assign stat_refreshes = stat_refreshes_q;
    assign stat_forced    = stat_forced_q;
`endif

endmodule

// File: tb/tb_bank_scheduler.sv
// Directed bench for bank_scheduler: vector table for arbitration/busy windows,
// hand-written sequences for refresh, interval change and reset-during-refresh.
module tb_bank_scheduler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  arb_mode;
    logic [31:0] refresh_interval;
    logic [3:0]  bank_busy;
    logic        ref_active;
    logic [3:0]  ref_pending;
    logic        idle;
    logic [1:0]  state_dbg;
`ifdef SCHED_STATS_EN
    logic [15:0] stat_grants;
    logic [15:0] stat_refreshes;
    logic [15:0] stat_forced;
`endif

    bank_scheduler_if #(.CHANNELS(4), .BANK_BITS(2)) bus ();

    bank_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .arb_mode         (arb_mode),
        .refresh_interval (refresh_interval),
        .bus              (bus),
        .bank_busy        (bank_busy),
        .ref_active       (ref_active),
        .ref_pending      (ref_pending),
        .idle             (idle),
        .state_dbg        (state_dbg)
`ifdef SCHED_STATS_EN
        ,
        .stat_grants      (stat_grants),
        .stat_refreshes   (stat_refreshes),
        .stat_forced      (stat_forced)
`endif
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        enable           = 1'b0;
        arb_mode         = 2'd0;
        refresh_interval = 32'd0;
        bus.req          = '0;
        bus.req_bank     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [1:0] t_bank;

    // ch0 requests continuously and moves to the next bank after every grant.
    task automatic step_traffic();
        step();
        if (bus.grant[0]) begin
            t_bank       = t_bank + 2'd1;
            bus.req_bank = {6'd0, t_bank};
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] req;
        logic [7:0] rb;
        logic [1:0] mode;
        logic       en;
        logic [3:0] g;
        logic [1:0] gb;
        logic [3:0] busy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] req, input logic [7:0] rb, input logic [1:0] mode,
                       input logic en, input logic [3:0] g, input logic [1:0] gb,
                       input logic [3:0] busy);
        vec_t v;
        v.req = req; v.rb = rb; v.mode = mode; v.en = en; v.g = g; v.gb = gb; v.busy = busy;
        vq.push_back(v);
    endtask

    int  cyc;
    int  len;
    int  bad;
    bit  found;
    bit  prev_zero;
    bit  late;
    logic [5:0] exp_rec;

    initial begin
        t_bank = 2'd0;
        do_reset();

        // reset state
        check("rst_grant", bus.grant, 0);
        check("rst_grant_valid", bus.grant_valid, 0);
        check("rst_grant_bank", bus.grant_bank, 0);
        check("rst_bank_busy", bank_busy, 0);
        check("rst_ref_active", ref_active, 0);
        check("rst_ref_pending", ref_pending, 0);
        check("rst_idle", idle, 1);

        // all four to distinct banks, round-robin from pointer 0
        add(4'b1111, 8'he4, 2'd0, 1'b1, 4'b0001, 2'd0, 4'b0001);
        add(4'b1110, 8'he4, 2'd0, 1'b1, 4'b0010, 2'd1, 4'b0011);
        add(4'b1100, 8'he4, 2'd0, 1'b1, 4'b0100, 2'd2, 4'b0111);
        add(4'b1000, 8'he4, 2'd0, 1'b1, 4'b1000, 2'd3, 4'b1111);
        add(4'b0000, 8'he4, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b1110);
        add(4'b0000, 8'he4, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b1100);
        add(4'b0000, 8'he4, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b1000);
        add(4'b0000, 8'he4, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0000);
        // ch0 and ch1 both on bank 1: ch1 waits out the busy window
        add(4'b0011, 8'h05, 2'd0, 1'b1, 4'b0001, 2'd1, 4'b0010);
        add(4'b0010, 8'h05, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0010);
        add(4'b0010, 8'h05, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0010);
        add(4'b0010, 8'h05, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0010);
        add(4'b0010, 8'h05, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0000);
        add(4'b0010, 8'h05, 2'd0, 1'b1, 4'b0010, 2'd1, 4'b0010);
        add(4'b0000, 8'h05, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0010);
        add(4'b0000, 8'h05, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0010);
        add(4'b0000, 8'h05, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0010);
        add(4'b0000, 8'h05, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0000);
        // single request ch1 -> bank 2, busy for exactly four cycles
        add(4'b0010, 8'h08, 2'd0, 1'b1, 4'b0010, 2'd2, 4'b0100);
        add(4'b0000, 8'h08, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0100);
        add(4'b0000, 8'h08, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0100);
        add(4'b0000, 8'h08, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0100);
        add(4'b0000, 8'h08, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0000);
        // fixed priority, everyone on bank 2: ch0 wins (round-robin would pick ch2)
        add(4'b1111, 8'haa, 2'd1, 1'b1, 4'b0001, 2'd2, 4'b0100);
        add(4'b1110, 8'haa, 2'd1, 1'b1, 4'b0000, 2'd0, 4'b0100);
        add(4'b1110, 8'haa, 2'd1, 1'b1, 4'b0000, 2'd0, 4'b0100);
        add(4'b1110, 8'haa, 2'd1, 1'b1, 4'b0000, 2'd0, 4'b0100);
        add(4'b1111, 8'haa, 2'd1, 1'b1, 4'b0000, 2'd0, 4'b0000);
        add(4'b1111, 8'haa, 2'd1, 1'b1, 4'b0001, 2'd2, 4'b0100);
        add(4'b1110, 8'haa, 2'd1, 1'b1, 4'b0000, 2'd0, 4'b0100);
        // enable low blocks grants even with free banks
        add(4'b1110, 8'he4, 2'd1, 1'b0, 4'b0000, 2'd0, 4'b0100);
        add(4'b1110, 8'he4, 2'd1, 1'b1, 4'b0010, 2'd1, 4'b0110);
        // round-robin skips ch2 (bank 2 still busy) and takes ch3
        add(4'b1100, 8'he4, 2'd0, 1'b1, 4'b1000, 2'd3, 4'b1010);
        add(4'b0100, 8'he4, 2'd0, 1'b1, 4'b0100, 2'd2, 4'b1110);
        add(4'b0000, 8'he4, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b1110);
        add(4'b0000, 8'he4, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b1100);
        add(4'b0000, 8'he4, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0100);
        add(4'b0000, 8'he4, 2'd0, 1'b1, 4'b0000, 2'd0, 4'b0000);

        foreach (vq[i]) begin
            bus.req      = vq[i].req;
            bus.req_bank = vq[i].rb;
            arb_mode     = vq[i].mode;
            enable       = vq[i].en;
            exp_q.push_back({vq[i].g, vq[i].gb});
            step();
            exp_rec = exp_q.pop_front();
            check($sformatf("vec%0d_grant", i), bus.grant, exp_rec[5:2]);
            check($sformatf("vec%0d_grant_valid", i), bus.grant_valid, (exp_rec[5:2] != 4'd0));
            if (exp_rec[5:2] != 4'd0)
                check($sformatf("vec%0d_grant_bank", i), bus.grant_bank, exp_rec[1:0]);
            check($sformatf("vec%0d_bank_busy", i), bank_busy, vq[i].busy);
            check($sformatf("vec%0d_idle", i), idle, (vq[i].busy == 4'd0));
        end
`ifdef SCHED_STATS_EN
        check("stat_grants_after_table", stat_grants, 12);
`endif

        // ---- opportunistic refresh: interval 10, no traffic ----
        do_reset();
        enable           = 1'b1;
        refresh_interval = 32'd10;
        found = 1'b0; cyc = 0;
        for (int c = 1; c <= 40 && !found; c++) begin
            step();
            if (ref_pending == 4'd1) begin
                found = 1'b1;
                cyc   = c;
            end
        end
        check("opp_first_debt_cycle", cyc, 10);
        refresh_interval = 32'd0;
        step();
        check("opp_drain_state", state_dbg, 1);
        check("opp_drain_ref_active", ref_active, 0);
        step();
        check("opp_refresh_start", ref_active, 1);
        len = 0; found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (ref_active) len++; else found = 1'b1;
            if (!found) step();
        end
        check("opp_refresh_length", len, 16);
        check("opp_pending_after", ref_pending, 0);
        check("opp_idle_after", idle, 1);
`ifdef SCHED_STATS_EN
        check("opp_stat_refreshes", stat_refreshes, 1);
`endif

        // ---- shrinking the interval below the running count wraps next cycle ----
        do_reset();
        refresh_interval = 32'd100;
        repeat (20) step();
        check("shrink_pending_before", ref_pending, 0);
        refresh_interval = 32'd5;
        step();
        check("shrink_wrap_next_cycle", ref_pending, 1);
        repeat (5) step();
        check("shrink_second_tick", ref_pending, 2);

        // ---- forced refresh under continuous traffic ----
        do_reset();
        enable           = 1'b1;
        arb_mode         = 2'd0;
        refresh_interval = 32'd10;
        t_bank           = 2'd0;
        bus.req          = 4'b0001;
        bus.req_bank     = 8'd0;
        found = 1'b0; cyc = 0;
        for (int c = 1; c <= 200 && !found; c++) begin
            step_traffic();
            if (ref_pending == 4'd8) begin
                found = 1'b1;
                cyc   = c;
            end
        end
        check("forced_debt_reaches_max_cycle", cyc, 80);
        refresh_interval = 32'd0;
        step_traffic();
        check("forced_drain_state", state_dbg, 1);
        check("forced_no_grant_on_entry", bus.grant, 0);
        bad = 0; late = 1'b0; found = 1'b0;
        prev_zero = (bank_busy == 4'd0);
        for (int c = 0; c < 20 && !found; c++) begin
            step_traffic();
            if (bus.grant != 4'd0) bad++;
            if (ref_active) begin
                found = 1'b1;
            end else begin
                if (prev_zero) late = 1'b1;
                prev_zero = (bank_busy == 4'd0);
            end
        end
        check("forced_drain_exit_on_idle_banks", {30'd0, found, prev_zero}, 32'd3);
        check("forced_drain_not_late", late, 0);
        len = 0; found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (bus.grant != 4'd0) bad++;
            if (ref_active) len++; else found = 1'b1;
            if (!found) step_traffic();
        end
        check("forced_refresh_length", len, 16);
        check("forced_no_grants_during_refresh", bad, 0);
        check("forced_pending_after", ref_pending, 7);
        check("forced_back_to_idle", state_dbg, 0);
`ifdef SCHED_STATS_EN
        check("forced_stat_forced", stat_forced, 1);
`endif

        // ---- reset in the middle of a refresh ----
        do_reset();
        enable           = 1'b1;
        refresh_interval = 32'd10;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (ref_active) found = 1'b1;
        end
        check("midrst_refresh_started", found, 1);
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ref_active", ref_active, 0);
        check("midrst_ref_pending", ref_pending, 0);
        check("midrst_idle", idle, 1);
        check("midrst_state", state_dbg, 0);
`ifdef SCHED_STATS_EN
        check("midrst_stat_refreshes", stat_refreshes, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bank_scheduler.md
# bank_scheduler

Cycle-level request scheduler that sits between the per-channel controllers and the shared memory banks. It selects at most one channel per cycle whose target bank is free, and marks that bank busy for a fixed recovery window. It also tracks refresh obligations from a programmable interval, postponing refresh while traffic is pending and forcing it once the postponement budget is exhausted.

## Interface
- CHANNELS, 4, number of requesting channels
- BANKS, 4, number of banks; power of two
- BANK_BITS, 2, log2(BANKS)
- MAX_POSTPONE, 8, refresh debt that forces a refresh; 1..15
- T_BUSY, 4, cycles a bank stays busy after a grant; must be ≥2
- T_RFC, 16, cycles a refresh occupies all banks; ≥1

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  permits new grants; refresh bookkeeping runs regardless
- arb_mode  in  2  0 = round-robin, 1 = fixed priority (index 0 highest), 2/3 = round-robin
- refresh_interval  in  32  cycles between refresh obligations; 0 disables the timer
- req  in  CHANNELS  per-channel request level
- req_bank  in  CHANNELS*BANK_BITS  packed target bank; channel i at [i*BANK_BITS +: BANK_BITS]
- grant  out  CHANNELS  one-hot, one-cycle grant pulse
- grant_valid  out  1  OR of grant
- grant_bank  out  BANK_BITS  bank of the current grant
- bank_busy  out  BANKS  per-bank busy flags
- ref_active  out  1  high while the refresh is executing
- ref_pending  out  4  outstanding refresh debt
- idle  out  1  FSM in IDLE and bank_busy == 0

## Operation
- The channel is eligible when: req[i] is high, bank_busy[req_bank_i] is low, enable is high, and the FSM is in IDLE with no refresh being taken this cycle.
- Round-robin uses a pointer at (last granted + 1) mod CHANNELS and scans upward with wrap. Fixed priority picks the lowest eligible index. The pointer updates only on a grant; it is kept in all modes.
- On a grant to channel c for bank b:
  - grant[c], grant_valid, and grant_bank=b are registered and high for exactly one cycle.
  - bank_busy[b] is set in the same cycle and stays high for T_BUSY cycles.
- Requester contract: a requester drops req, or changes req_bank, the cycle after it sees grant. T_BUSY ≥2 guarantees no duplicate grant.
- Refresh timer:
  - Increments every cycle while refresh_interval ≠ 0.
  - On reaching refresh_interval−1, it wraps to 0 and ref_pending increments, saturating at MAX_POSTPONE.
  - If refresh_interval changes to a value ≤ the current count, the timer wraps at the next cycle.
  - A simultaneous increment and decrement of ref_pending leaves it unchanged.
- FSM:
  - IDLE: arbitrates. Goes to DRAIN if ref_pending == MAX_POSTPONE (forced), or if ref_pending > 0 and req == 0 (opportunistic). No grant is issued in the transition cycle.
  - DRAIN: no grants. Goes to REFRESH when bank_busy == 0; the state lasts at least one cycle.
  - REFRESH: ref_active is high for exactly T_RFC cycles. On the last cycle, ref_pending decrements and the FSM returns to IDLE.
- Forced refresh takes priority over any pending req. When enable is low, no grants are issued, but refreshes still proceed.
- Reset values: grant=0, grant_valid=0, grant_bank=0, bank_busy=0, ref_active=0, ref_pending=0, idle=1; FSM=IDLE, timer=0, RR pointer=0.
- Asserting rst mid-grant or mid-refresh clears all outputs asynchronously. The aborted refresh is not credited.

## Timing
- Request latency: req sampled at edge k produces grant in cycle k..k+1, i.e. registered output visible after edge k. Minimum latency is 1 cycle.
- Throughput: at most one grant per cycle. Back-to-back grants are allowed only to different banks.
- bank_busy[b] is high from the grant cycle through T_BUSY cycles, then clears. The same bank can be granted again in the cycle after it clears.
- Minimum refresh cost with idle banks: 1 DRAIN cycle + T_RFC REFRESH cycles.

## Configuration
- SCHED_STATS_EN defined adds three outputs, each a 16-bit saturating counter reset to 0:
  - stat_grants: +1 per grant
  - stat_refreshes: +1 per completed refresh
  - stat_forced: +1 per forced DRAIN entry
- SCHED_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then req=0b0010, req_bank ch1=2 → grant=0b0010 and grant_bank=2 one cycle later; bank_busy[2] high for 4 cycles, then 0.
- All four channels request distinct banks, arb_mode=0 → grants in order ch0, ch1, ch2, ch3 on consecutive cycles. With arb_mode=1 and same-bank conflicts, ch0 always wins.
- ch0 and ch1 both target bank 1 → ch0 is granted, ch1 is held until bank_busy[1] clears, then granted the next cycle.
- refresh_interval=10 with continuous traffic → ref_pending climbs to 8. A forced refresh follows: DRAIN waits for busy banks, then ref_active is high for 16 cycles and ref_pending drops to 7.
- refresh_interval=10 with req=0 → an opportunistic refresh occurs after ref_pending=1, and ref_pending returns to 0.
- rst asserted in the middle of REFRESH → ref_active drops immediately, ref_pending=0, idle=1. Re-running with SCHED_STATS_EN shows stat_refreshes unchanged.
